// File: rtl/or1200_bench_pkg.sv
// Shared types and constants for the or1200 bench run controller.
// Optional halt support is enabled by defining OR1200_BENCH_HALT_EN.
package or1200_bench_pkg;

    localparam int CFG_IDX_W  = 4;
    localparam int MAX_CHECKS = 16;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        CHECK,
        DONE
    } bench_state_e;

endpackage

// File: rtl/or1200_bench_cmp.sv
// One compare channel: holds an expected value plus its enable and flags
// a mismatch against the observed value when enabled.
module or1200_bench_cmp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] obs,
    output logic          mismatch
);

    logic [DW-1:0] exp_q, exp_d;
    logic          en_q, en_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        exp_d = exp_q;
        en_d  = en_q;
        if (we) begin
            exp_d = wdata;
            en_d  = 1'b1;
        end
    end

    // NOTE: the expected value is reset too, because rst must clear it mid-run.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
            en_q  <= 1'b0;
        end else begin
            exp_q <= exp_d;
            en_q  <= en_d;
        end
    end

    assign mismatch = en_q && (obs != exp_q);

endmodule

// File: rtl/or1200_bench_ctrl.sv
// Run controller: holds CPU reset, runs a bounded window, then compares
// observed values against preloaded expectations. Early stop on halt is
// available when OR1200_BENCH_HALT_EN is defined.
module or1200_bench_ctrl
    import or1200_bench_pkg::*;
#(
    parameter int DW         = 32,
    parameter int NUM_CHECKS = 4,
    parameter int RST_CYCLES = 1,
    parameter int RUN_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_we,
    input  logic [CFG_IDX_W-1:0]     cfg_idx,
    input  logic [DW-1:0]            cfg_data,
    input  logic [NUM_CHECKS*DW-1:0] obs_data,
    input  logic                     halt,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [NUM_CHECKS-1:0]    fail_mask,
    output logic [CNT_W-1:0]         cycle_count
);

    bench_state_e            state_q, state_d;
    logic [CNT_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]        cycle_count_q, cycle_count_d;
    logic [NUM_CHECKS-1:0]   fail_mask_q, fail_mask_d;
    logic                    pass_q, pass_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cfg_open;
    logic                    run_last;
    logic [NUM_CHECKS-1:0]   mismatch;

    // Configuration and start are only accepted while no test is in flight.
    assign cfg_open = (state_q == IDLE) || (state_q == DONE);

    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_cmp
        or1200_bench_cmp #(.DW(DW)) u_cmp (
            .clk      (clk),
            .rst      (rst),
            .we       (cfg_open && cfg_we && (cfg_idx == CFG_IDX_W'(i))),
            .wdata    (cfg_data),
            .obs      (obs_data[i*DW +: DW]),
            .mismatch (mismatch[i])
        );
    end

`ifdef OR1200_BENCH_HALT_EN
    assign run_last = halt || (cycle_count_q + CNT_W'(1) == CNT_W'(RUN_CYCLES));
`else
    logic unused_halt;
    assign unused_halt = halt;
    assign run_last    = (cycle_count_q + CNT_W'(1) == CNT_W'(RUN_CYCLES));
`endif

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        fail_mask_d   = fail_mask_q;
        pass_d        = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = RESET;
                    rst_cnt_d     = CNT_W'(1);
                    cycle_count_d = '0;
                    fail_mask_d   = '0;
                    pass_d        = 1'b0;
                end
            end
            RESET: begin
                if (rst_cnt_q == CNT_W'(RST_CYCLES)) state_d = RUN;
                else rst_cnt_d = rst_cnt_q + CNT_W'(1);
            end
            RUN: begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
                if (run_last) state_d = CHECK;
            end
            CHECK: begin
                fail_mask_d = mismatch;
                pass_d      = ~|mismatch;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        cpu_rst_d = !((state_d == RUN) || (state_d == CHECK));
        busy_d    = (state_d == RESET) || (state_d == RUN) || (state_d == CHECK);
        done_d    = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            fail_mask_q   <= '0;
            pass_q        <= 1'b0;
            cpu_rst_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            fail_mask_q   <= fail_mask_d;
            pass_q        <= pass_d;
            cpu_rst_q     <= cpu_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_mask   = fail_mask_q;
    assign cycle_count = cycle_count_q;

endmodule
